// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the pmem arbiter: access-size encodings, FSM states,
// grant identities and the store-size aliasing helper.
package mem_arbiter_pkg;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_RESP,
    ST_ERR
  } state_t;

  typedef enum logic {
    GRANT_IFU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_t;

  // Stores ignore the unsigned bit, so 100/101 behave as byte/half writes.
  function automatic logic [2:0] eff_size(input logic we, input logic [2:0] size);
    return we ? {1'b0, size[1:0]} : size;
  endfunction

endpackage

// File: rtl/mem_arbiter_align.sv
// Combinational sub-word datapath: store byte-lane placement and mask,
// load extraction with sign/zero extension, alignment and size legality.
module mem_arbiter_align
  import mem_arbiter_pkg::*;
(
  input  logic [2:0]  size,
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic [31:0] load_data,
  output logic        misalign,
  output logic        illegal
);

  logic [4:0]  sh_amt;
  logic [31:0] s;

  assign sh_amt   = {addr_lo, 3'b000};
  assign s        = rdata >> sh_amt;
  assign wdata_sh = wdata << sh_amt;

  always_comb begin
    wmask     = 4'b0000;
    load_data = s;
    misalign  = 1'b0;
    illegal   = 1'b0;
    case (eff_size(we, size))
      SZ_B: begin
        wmask     = 4'b0001 << addr_lo;
        load_data = {{24{s[7]}}, s[7:0]};
      end
      SZ_BU: begin
        wmask     = 4'b0001 << addr_lo;
        load_data = {24'b0, s[7:0]};
      end
      SZ_H: begin
        wmask     = 4'b0011 << addr_lo;
        load_data = {{16{s[15]}}, s[15:0]};
        misalign  = addr_lo[0];
      end
      SZ_HU: begin
        wmask     = 4'b0011 << addr_lo;
        load_data = {16'b0, s[15:0]};
        misalign  = addr_lo[0];
      end
      SZ_W: begin
        wmask    = 4'b1111;
        misalign = |addr_lo;
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one pmem port between instruction fetch and
// load/store, one transaction in flight, with timeout and sub-word handling.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  output logic        ifu_resp_err,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_size,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        lsu_resp_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata
);

  state_t            state_reg, state_next;
  grant_t            last_grant_reg, grant_reg;
  logic [31:0]       addr_reg, wdata_reg;
  logic              we_reg;
  logic [2:0]        size_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic              ifu_resp_valid_reg, ifu_resp_err_reg;
  logic              lsu_resp_valid_reg, lsu_resp_err_reg;
  logic [31:0]       ifu_rdata_reg, lsu_rdata_reg;

  logic              is_idle, pick_ifu, pick_lsu, accept, timeout;
  logic [31:0]       al_addr, al_wdata, al_wdata_sh, al_load;
  logic [2:0]        al_size;
  logic              al_we, al_misalign, al_illegal;
  logic [3:0]        al_wmask;
  logic              resp_fire, resp_err;
  logic [31:0]       resp_data;

  assign is_idle       = (state_reg == ST_IDLE);
  assign pick_ifu      = ifu_req_valid && (!lsu_req_valid || last_grant_reg == GRANT_LSU);
  assign pick_lsu      = lsu_req_valid && !pick_ifu;
  assign accept        = is_idle && (pick_ifu || pick_lsu);
  assign ifu_req_ready = is_idle && pick_ifu;
  assign lsu_req_ready = is_idle && pick_lsu;
  assign timeout       = (cnt_reg == CNT_W'(TIMEOUT - 1));

  // The single align unit looks at the incoming winner while idle and at the
  // latched transaction afterwards, so error detection and data formatting share it.
  always_comb begin
    al_addr  = addr_reg;
    al_we    = we_reg;
    al_size  = size_reg;
    al_wdata = wdata_reg;
    if (is_idle) begin
      if (pick_ifu) begin
        al_addr  = ifu_addr;
        al_we    = 1'b0;
        al_size  = SZ_W;
        al_wdata = '0;
      end else begin
        al_addr  = lsu_addr;
        al_we    = lsu_we;
        al_size  = lsu_size;
        al_wdata = lsu_wdata;
      end
    end
  end

  mem_arbiter_align u_align (
    .size      (al_size),
    .we        (al_we),
    .addr_lo   (al_addr[1:0]),
    .wdata     (al_wdata),
    .rdata     (mem_rdata),
    .wmask     (al_wmask),
    .wdata_sh  (al_wdata_sh),
    .load_data (al_load),
    .misalign  (al_misalign),
    .illegal   (al_illegal)
  );

  always_comb begin
    state_next = state_reg;
    resp_fire  = 1'b0;
    resp_err   = 1'b0;
    resp_data  = '0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) state_next = (al_misalign || al_illegal) ? ST_ERR : ST_REQ;
      end
      ST_REQ: begin
        if (timeout) begin
          state_next = ST_RESP;
          resp_fire  = 1'b1;
          resp_err   = 1'b1;
        end else if (mem_req_ready) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          state_next = ST_RESP;
          resp_fire  = 1'b1;
          resp_data  = we_reg ? 32'd0 : al_load;
        end else if (timeout) begin
          state_next = ST_RESP;
          resp_fire  = 1'b1;
          resp_err   = 1'b1;
        end
      end
      ST_RESP: state_next = ST_IDLE;
      ST_ERR: begin
        state_next = ST_IDLE;
        resp_fire  = 1'b1;
        resp_err   = 1'b1;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Response registers load on the edge leaving WAIT/REQ/ERR, so the pulse is
  // seen during RESP, or during the IDLE cycle that follows ERR.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= ST_IDLE;
      last_grant_reg     <= GRANT_LSU;
      grant_reg          <= GRANT_LSU;
      addr_reg           <= '0;
      wdata_reg          <= '0;
      we_reg             <= 1'b0;
      size_reg           <= '0;
      cnt_reg            <= '0;
      ifu_resp_valid_reg <= 1'b0;
      ifu_resp_err_reg   <= 1'b0;
      ifu_rdata_reg      <= '0;
      lsu_resp_valid_reg <= 1'b0;
      lsu_resp_err_reg   <= 1'b0;
      lsu_rdata_reg      <= '0;
    end else begin
      state_reg          <= state_next;
      ifu_resp_valid_reg <= resp_fire && (grant_reg == GRANT_IFU);
      lsu_resp_valid_reg <= resp_fire && (grant_reg == GRANT_LSU);
      if (resp_fire) begin
        if (grant_reg == GRANT_IFU) begin
          ifu_rdata_reg    <= resp_data;
          ifu_resp_err_reg <= resp_err;
        end else begin
          lsu_rdata_reg    <= resp_data;
          lsu_resp_err_reg <= resp_err;
        end
      end
      if (accept) begin
        grant_reg      <= pick_ifu ? GRANT_IFU : GRANT_LSU;
        last_grant_reg <= pick_ifu ? GRANT_IFU : GRANT_LSU;
        addr_reg       <= al_addr;
        we_reg         <= al_we;
        size_reg       <= al_size;
        wdata_reg      <= al_wdata;
        cnt_reg        <= '0;
      end else if (state_reg == ST_REQ || state_reg == ST_WAIT) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign ifu_resp_valid = ifu_resp_valid_reg;
  assign ifu_rdata      = ifu_rdata_reg;
  assign ifu_resp_err   = ifu_resp_err_reg;
  assign lsu_resp_valid = lsu_resp_valid_reg;
  assign lsu_rdata      = lsu_rdata_reg;
  assign lsu_resp_err   = lsu_resp_err_reg;

  assign mem_req_valid = (state_reg == ST_REQ);
  assign mem_we        = mem_req_valid && we_reg;
  assign mem_addr      = mem_req_valid ? {addr_reg[31:2], 2'b00} : 32'd0;
  assign mem_wdata     = mem_req_valid ? al_wdata_sh : 32'd0;
  assign mem_wmask     = mem_we ? al_wmask : 4'b0000;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a cycle-level transaction model predicts
// readies, memory requests and response pulses; literal checks pin the model.
module tb_mem_arbiter;

  localparam int TO = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifu_req_valid = 1'b0;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr = '0;
  logic        ifu_resp_valid;
  logic [31:0] ifu_rdata;
  logic        ifu_resp_err;
  logic        lsu_req_valid = 1'b0;
  logic        lsu_req_ready;
  logic        lsu_we = 1'b0;
  logic [2:0]  lsu_size = '0;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic        lsu_resp_valid;
  logic [31:0] lsu_rdata;
  logic        lsu_resp_err;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_resp_valid;
  logic [31:0] mem_rdata;

  logic [31:0] mem_word = '0;
  logic        mem_respond = 1'b1;
  logic        resp_pulse = 1'b0;
  logic        stray_pulse = 1'b0;

  assign mem_resp_valid = resp_pulse | stray_pulse;
  assign mem_rdata      = mem_word;

  mem_arbiter #(.TIMEOUT(TO), .CNT_W(9)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_we(lsu_we),
    .lsu_size(lsu_size), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata), .lsu_resp_err(lsu_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory: accepts immediately, answers one cycle after the handshake.
  initial begin : responder
    logic hs;
    forever begin
      @(negedge clk);
      hs = mem_req_valid && mem_req_ready && mem_respond;
      @(posedge clk);
      #1 resp_pulse = hs;
    end
  end

  function automatic bit bad_req(input bit we, input logic [2:0] sz, input logic [1:0] a);
    logic [2:0] e;
    e = we ? {1'b0, sz[1:0]} : sz;
    case (e)
      3'b000, 3'b100: return 1'b0;
      3'b001, 3'b101: return a[0];
      3'b010:         return a != 2'd0;
      default:        return 1'b1;
    endcase
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] sz, input logic [1:0] a,
                                           input logic [31:0] w);
    logic [7:0] b [4];
    logic [7:0] lo, hi;
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    lo = b[a];
    hi = b[a + 2'd1];
    case (sz)
      3'b000:  return {{24{lo[7]}}, lo};
      3'b100:  return {24'd0, lo};
      3'b001:  return {{16{hi[7]}}, hi, lo};
      3'b101:  return {16'd0, hi, lo};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] mask_of(input logic [2:0] sz, input logic [1:0] a);
    logic [3:0] m;
    m = 4'b0000;
    case (sz[1:0])
      2'b00: m[a] = 1'b1;
      2'b01: begin m[a] = 1'b1; m[a + 2'd1] = 1'b1; end
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Transaction model state
  int          next_free = 0, mreq_cyc = -1, resp_cyc = -1;
  bit          resp_ifu, resp_err_e, last_lsu = 1'b1;
  logic [31:0] resp_data_e, e_maddr, e_mwdata;
  logic [3:0]  e_mwmask;
  bit          e_mwe;
  logic [31:0] hold_ifu_d = '0, hold_lsu_d = '0;
  bit          hold_ifu_e = 1'b0, hold_lsu_e = 1'b0;

  // Observations used by the literal checks
  int          acc_ifu = 0, acc_lsu = 0, lat_ifu = 0, lat_lsu = 0;
  int          memreq_count = 0, ifu_resp_count = 0, lsu_resp_count = 0;
  logic [31:0] obs_maddr = '0, obs_mwdata = '0;
  logic [3:0]  obs_mwmask = '0;
  logic [7:0]  grant_log = '0;

  always @(negedge clk) begin : compare
    bit          idle, exp_ir, exp_lr, exp_iv, exp_lv;
    bit          we_s;
    logic [2:0]  sz_s;
    logic [31:0] addr_s, wd_s;
    if (rst_q) begin
      next_free  = cyc;
      mreq_cyc   = -1;
      resp_cyc   = -1;
      last_lsu   = 1'b1;
      hold_ifu_d = '0; hold_ifu_e = 1'b0;
      hold_lsu_d = '0; hold_lsu_e = 1'b0;
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wdata", mem_wdata, 32'd0);
      chk("rst_mem_ctl", {27'd0, mem_we, mem_wmask}, 32'd0);
    end
    idle   = (cyc >= next_free);
    exp_ir = idle && ifu_req_valid && (!lsu_req_valid || last_lsu);
    exp_lr = idle && lsu_req_valid && !exp_ir;
    chk("ifu_req_ready", 32'(ifu_req_ready), 32'(exp_ir));
    chk("lsu_req_ready", 32'(lsu_req_ready), 32'(exp_lr));
    chk("mem_req_valid", 32'(mem_req_valid), 32'(cyc == mreq_cyc));
    if (cyc == mreq_cyc) begin
      chk("mem_addr", mem_addr, e_maddr);
      chk("mem_wdata", mem_wdata, e_mwdata);
      chk("mem_wmask", 32'(mem_wmask), 32'(e_mwmask));
      chk("mem_we", 32'(mem_we), 32'(e_mwe));
    end
    exp_iv = (cyc == resp_cyc) && resp_ifu;
    exp_lv = (cyc == resp_cyc) && !resp_ifu;
    chk("ifu_resp_valid", 32'(ifu_resp_valid), 32'(exp_iv));
    chk("lsu_resp_valid", 32'(lsu_resp_valid), 32'(exp_lv));
    if (exp_iv) begin hold_ifu_d = resp_data_e; hold_ifu_e = resp_err_e; end
    if (exp_lv) begin hold_lsu_d = resp_data_e; hold_lsu_e = resp_err_e; end
    chk("ifu_rdata", ifu_rdata, hold_ifu_d);
    chk("ifu_resp_err", 32'(ifu_resp_err), 32'(hold_ifu_e));
    chk("lsu_rdata", lsu_rdata, hold_lsu_d);
    chk("lsu_resp_err", 32'(lsu_resp_err), 32'(hold_lsu_e));

    if (mem_req_valid) begin
      memreq_count++;
      obs_maddr = mem_addr; obs_mwdata = mem_wdata; obs_mwmask = mem_wmask;
    end
    if (ifu_req_ready) begin acc_ifu = cyc; grant_log = {grant_log[6:0], 1'b0}; end
    if (lsu_req_ready) begin acc_lsu = cyc; grant_log = {grant_log[6:0], 1'b1}; end
    if (ifu_resp_valid) begin lat_ifu = cyc - acc_ifu; ifu_resp_count++; end
    if (lsu_resp_valid) begin lat_lsu = cyc - acc_lsu; lsu_resp_count++; end

    if (!rst && (exp_ir || exp_lr)) begin
      if (exp_ir) begin
        we_s = 1'b0; sz_s = 3'b010; addr_s = ifu_addr; wd_s = '0;
      end else begin
        we_s = lsu_we; sz_s = lsu_size; addr_s = lsu_addr; wd_s = lsu_wdata;
      end
      last_lsu = exp_lr;
      resp_ifu = exp_ir;
      if (bad_req(we_s, sz_s, addr_s[1:0])) begin
        mreq_cyc    = -1;
        resp_cyc    = cyc + 2;
        resp_err_e  = 1'b1;
        resp_data_e = '0;
        next_free   = cyc + 2;
      end else begin
        mreq_cyc = cyc + 1;
        e_maddr  = {addr_s[31:2], 2'b00};
        e_mwe    = we_s;
        e_mwdata = wd_s << (8 * addr_s[1:0]);
        e_mwmask = we_s ? mask_of(sz_s, addr_s[1:0]) : 4'b0000;
        if (mem_respond) begin
          resp_cyc    = cyc + 3;
          resp_err_e  = 1'b0;
          resp_data_e = we_s ? 32'd0 : load_val(sz_s, addr_s[1:0], mem_word);
          next_free   = cyc + 4;
        end else begin
          resp_cyc    = cyc + 1 + TO;
          resp_err_e  = 1'b1;
          resp_data_e = '0;
          next_free   = cyc + 2 + TO;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ifu_req(input logic [31:0] a);
    ifu_addr = a; ifu_req_valid = 1'b1;
  endtask

  task automatic lsu_req(input logic we, input logic [2:0] sz, input logic [31:0] a,
                         input logic [31:0] wd);
    lsu_we = we; lsu_size = sz; lsu_addr = a; lsu_wdata = wd; lsu_req_valid = 1'b1;
  endtask

  task automatic run_reqs();
    int  n;
    logic ir, lr;
    n = 0;
    while ((ifu_req_valid || lsu_req_valid) && n < 1000) begin
      @(negedge clk);
      ir = ifu_req_ready;
      lr = lsu_req_ready;
      tick();
      if (ir) ifu_req_valid = 1'b0;
      if (lr) lsu_req_valid = 1'b0;
      n++;
    end
    if (n >= 1000) begin
      n_checks++; n_fail++;
      $display("FAIL accept_bound: no ready within %0d cycles, required a grant", n);
      ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    end
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (cyc <= next_free && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) begin
      n_checks++; n_fail++;
      $display("FAIL settle_bound: still busy after %0d cycles, required idle", n);
    end
  endtask

  typedef struct {
    bit          ifu;
    bit          we;
    logic [2:0]  sz;
    logic [31:0] addr;
    logic [31:0] wd;
  } vec_t;

  vec_t vecs [10] = '{
    '{1'b0, 1'b0, 3'b001, 32'h8000_0002, 32'h0},
    '{1'b0, 1'b0, 3'b101, 32'h8000_0002, 32'h0},
    '{1'b0, 1'b0, 3'b001, 32'h8000_0001, 32'h0},
    '{1'b0, 1'b0, 3'b011, 32'h8000_0000, 32'h0},
    '{1'b0, 1'b1, 3'b000, 32'h8000_0001, 32'h0000_00A5},
    '{1'b0, 1'b1, 3'b110, 32'h8000_0004, 32'h1234_5678},
    '{1'b0, 1'b1, 3'b111, 32'h8000_0004, 32'h1234_5678},
    '{1'b1, 1'b0, 3'b010, 32'h8000_0002, 32'h0},
    '{1'b0, 1'b0, 3'b010, 32'h8000_0008, 32'h0},
    '{1'b0, 1'b0, 3'b000, 32'h8000_0001, 32'h0}
  };

  initial begin : stim
    int base;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Fetch with zero-wait memory
    mem_word = 32'hDEAD_BEEF;
    ifu_req(32'h8000_0004);
    run_reqs();
    settle();
    chk("t1_latency", lat_ifu, 32'd3);
    chk("t1_rdata", ifu_rdata, 32'hDEAD_BEEF);
    chk("t1_err", 32'(ifu_resp_err), 32'd0);

    // Signed and unsigned byte loads from the top lane
    mem_word = 32'h80FF_1234;
    lsu_req(1'b0, 3'b000, 32'h8000_0003, 32'h0);
    run_reqs();
    settle();
    chk("t3_lb", lsu_rdata, 32'hFFFF_FF80);
    lsu_req(1'b0, 3'b100, 32'h8000_0003, 32'h0);
    run_reqs();
    settle();
    chk("t3_lbu", lsu_rdata, 32'h0000_0080);

    // Halfword store to the upper half
    lsu_req(1'b1, 3'b001, 32'h8000_0002, 32'h0000_ABCD);
    run_reqs();
    settle();
    chk("t4_wmask", 32'(obs_mwmask), 32'h0000_000C);
    chk("t4_wdata", obs_mwdata, 32'hABCD_0000);
    chk("t4_addr", obs_maddr, 32'h8000_0000);
    chk("t4_store_rdata", lsu_rdata, 32'd0);

    // Misaligned word load never reaches memory
    base = memreq_count;
    lsu_req(1'b0, 3'b010, 32'h8000_0001, 32'h0);
    run_reqs();
    settle();
    chk("t5_no_memreq", memreq_count, base);
    chk("t5_latency", lat_lsu, 32'd2);
    chk("t5_err", 32'(lsu_resp_err), 32'd1);
    chk("t5_rdata", lsu_rdata, 32'd0);

    // Assorted sizes, alignments and illegal encodings, model-checked
    mem_word = 32'h80FF_1234;
    foreach (vecs[i]) begin
      if (vecs[i].ifu) ifu_req(vecs[i].addr);
      else lsu_req(vecs[i].we, vecs[i].sz, vecs[i].addr, vecs[i].wd);
      run_reqs();
      settle();
    end
    lsu_req(1'b0, 3'b001, 32'h8000_0002, 32'h0);
    run_reqs();
    settle();
    chk("lh_upper", lsu_rdata, 32'hFFFF_80FF);

    // Tie arbitration right after reset, twice
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mem_word  = 32'h1122_3344;
    grant_log = '0;
    for (int r = 0; r < 2; r++) begin
      ifu_req(32'h8000_0100);
      lsu_req(1'b0, 3'b010, 32'h8000_0200, 32'h0);
      run_reqs();
      settle();
    end
    chk("t2_grant_order", 32'(grant_log[3:0]), 32'h0000_0005);

    // Memory accepts but never answers
    mem_respond = 1'b0;
    lsu_req(1'b0, 3'b010, 32'h8000_0010, 32'h0);
    run_reqs();
    settle();
    chk("t6_timeout_latency", lat_lsu, 32'(TO + 1));
    chk("t6_timeout_err", 32'(lsu_resp_err), 32'd1);

    // Reset while waiting; a late memory response must be dropped
    ifu_req(32'h8000_0020);
    run_reqs();
    repeat (5) tick();
    base = ifu_resp_count;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    stray_pulse = 1'b1;
    tick();
    stray_pulse = 1'b0;
    repeat (10) tick();
    chk("rst_no_response", ifu_resp_count, base);
    chk("rst_ifu_rdata", ifu_rdata, 32'd0);

    // Normal operation resumes
    mem_respond = 1'b1;
    mem_word    = 32'hCAFE_F00D;
    ifu_req(32'h8000_0030);
    run_reqs();
    settle();
    chk("recover_rdata", ifu_rdata, 32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
